// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// nibble_serial_adder_ctrl_pkg: shared state encoding and nibble width for the serial adder
package nibble_serial_adder_ctrl_pkg;
    localparam int NIBBLE_W = 4;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/carry_select_adder.sv
// carry_select_adder: 4-bit adder, low pair ripples, high pair precomputed for both carries
module carry_select_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    logic [2:0] lo, hi0, hi1;
    assign lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b0, c_in};
    assign hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    assign hi1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;
    assign sum   = {lo[2] ? hi1[1:0] : hi0[1:0], lo[1:0]};
    assign c_out = lo[2] ? hi1[2] : hi0[2];
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: WIDTH-bit add/sub sequenced through one 4-bit adder, LSB nibble first
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);
    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CW = $clog2(NIBBLES);

    state_t state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r;
    logic carry, accept, last, nib_c;
    logic [CW-1:0] nib_cnt;
    logic [NIBBLE_W-1:0] a_nib, b_nib, nib_sum;

    assign accept = in_valid & in_ready;
    assign last   = nib_cnt == CW'(NIBBLES - 1);
    assign a_nib  = a_r[nib_cnt*NIBBLE_W +: NIBBLE_W];
    assign b_nib  = b_r[nib_cnt*NIBBLE_W +: NIBBLE_W];

    carry_select_adder u_csa (
        .a     (a_nib),
        .b     (b_nib),
        .c_in  (carry),
        .sum   (nib_sum),
        .c_out (nib_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        in_ready  = (state == ST_IDLE) || (state == ST_DONE && out_ready);
        out_valid = state == ST_DONE;
        state_nxt = accept                           ? ST_RUN  :
                    (state == ST_RUN && last)        ? ST_DONE :
                    (state == ST_DONE && out_ready)  ? ST_IDLE : state;
    end

    // b is stored pre-inverted for subtract so RUN is identical for both modes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            carry    <= 1'b0;
            nib_cnt  <= '0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_r      <= a;
            b_r      <= sub ? ~b : b;
            carry    <= sub | c_in;
            nib_cnt  <= '0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else if (state == ST_RUN) begin
            sum[nib_cnt*NIBBLE_W +: NIBBLE_W] <= nib_sum;
            carry <= nib_c;
            if (!last) nib_cnt <= nib_cnt + 1'b1;
            if (last) begin
                c_out    <= nib_c;
                overflow <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (nib_sum[NIBBLE_W-1] != a_r[WIDTH-1]);
            end
        end
    end
endmodule
